// File: rtl/cpu_run_controller.sv
// Life-cycle sequencer for the 8-bit single-cycle core: streams a program into
// instruction memory, then resets and runs the core with pause/step/abort/halt control.
module cpu_run_controller #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 24,
  parameter int CNT_W   = 16
) (
  input  logic               CLK,
  input  logic               reset,
  input  logic               load_start,
  input  logic               go,
  input  logic               pause,
  input  logic               step,
  input  logic               abort,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [7:0]         in_data,
  output logic               imem_we,
  output logic [ADDR_W-1:0]  imem_waddr,
  output logic [INSTR_W-1:0] imem_wdata,
  input  logic [ADDR_W-1:0]  pc,
  input  logic [INSTR_W-1:0] instr,
  output logic               core_reset,
  output logic               core_en,
  output logic               loaded,
  output logic               running,
  output logic               halted,
  output logic [CNT_W-1:0]   cycle_count,
  output logic [3:0]         state_dbg
);

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    LD_HDR   = 4'd1,
    LD_B2    = 4'd2,
    LD_B1    = 4'd3,
    LD_B0    = 4'd4,
    CORE_RST = 4'd5,
    RUN      = 4'd6,
    PAUSE    = 4'd7,
    STEP     = 4'd8,
    HALTED   = 4'd9
  } state_t;

  localparam logic [ADDR_W:0] WORD_ONE  = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W:0] WORD_FULL = (ADDR_W + 1)'(1 << ADDR_W);

  state_t          state, next_state;
  logic [7:0]      b2, b1;
  logic [ADDR_W:0] words_rem;
  logic            last_wr;
  logic            ld_state, xfer, halt_hit;

  // Byte stream: a byte moves when in_valid && in_ready; in_ready is decoded
  // from the state register alone, so the producer never sees a comb path back.
  assign ld_state   = (state == LD_HDR) || (state == LD_B2) || (state == LD_B1) || (state == LD_B0);
  assign in_ready   = ld_state;
  assign xfer       = in_valid && ld_state;
  assign core_en    = (state == CORE_RST) || (state == RUN) || (state == STEP);
  assign core_reset = ld_state || (state == IDLE) || (state == CORE_RST);
  assign running    = (state == RUN) || (state == STEP);
  assign halted     = (state == HALTED);
  assign state_dbg  = state;

  // Always-taken branch whose target is its own address.
  assign halt_hit = (instr[23:20] == 4'b0111) && (instr[15:12] == instr[11:8]) &&
                    (instr[7:0] == pc);

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (abort) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE, HALTED: begin
          if (go && loaded)    next_state = CORE_RST;
          else if (load_start) next_state = LD_HDR;
        end
        LD_HDR:   if (xfer) next_state = LD_B2;
        LD_B2:    if (xfer) next_state = LD_B1;
        LD_B1:    if (xfer) next_state = LD_B0;
        LD_B0:    if (xfer) next_state = (words_rem == WORD_ONE) ? IDLE : LD_B2;
        CORE_RST: next_state = RUN;
        RUN: begin
          if (halt_hit)   next_state = HALTED;
          else if (pause) next_state = PAUSE;
        end
        PAUSE: begin
          if (step)    next_state = STEP;
          else if (go) next_state = RUN;
        end
        STEP:     next_state = halt_hit ? HALTED : PAUSE;
        default:  next_state = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      imem_we     <= 1'b0;
      imem_waddr  <= '0;
      imem_wdata  <= '0;
      b2          <= '0;
      b1          <= '0;
      words_rem   <= '0;
      last_wr     <= 1'b0;
      loaded      <= 1'b0;
      cycle_count <= '0;
    end else begin
      imem_we <= 1'b0;
      // The address advances once its write has landed, except after the final word.
      if (imem_we && !last_wr) imem_waddr <= imem_waddr + ADDR_W'(1);
      if (xfer && !abort) begin
        case (state)
          LD_HDR: begin
            words_rem  <= (in_data == 8'd0) ? WORD_FULL : (ADDR_W + 1)'(in_data);
            imem_waddr <= '0;
          end
          LD_B2: b2 <= in_data;
          LD_B1: b1 <= in_data;
          LD_B0: begin
            imem_wdata <= {b2, b1, in_data};
            imem_we    <= 1'b1;
            last_wr    <= (words_rem == WORD_ONE);
            words_rem  <= words_rem - WORD_ONE;
            if (words_rem == WORD_ONE) loaded <= 1'b1;
          end
          default: ;
        endcase
      end
      if ((next_state == LD_HDR) && !ld_state) loaded <= 1'b0;
      if (abort && ld_state)                    loaded <= 1'b0;
      if (state == CORE_RST) begin
        cycle_count <= '0;
      end else if (((state == RUN) || (state == STEP)) && (cycle_count != '1)) begin
        cycle_count <= cycle_count + CNT_W'(1);
      end
    end
  end

endmodule
